// File: rtl/i2c_als_pkg.sv
// Shared types and constants for the ambient-light-sensor I2C responder model.
package i2c_als_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck
    } als_state_e;

    localparam logic [7:0] CTRL_REG         = 8'h00;
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h39;

endpackage

// File: rtl/i2c_als_if.sv
// I2C target-side bus lines: sampled SCL/SDA in, open-drain SDA pull-down out.
interface i2c_als_if;

    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);

endinterface

// File: rtl/i2c_bus_cond.sv
// Synchronises SCL/SDA, optionally majority-filters them (I2C_ALS_GLITCH_FILTER_EN),
// and produces SCL edge and START/STOP strobes.
module i2c_bus_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_s, sda_s;
    logic scl, scl_prev_q, sda_prev_q;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_ALS_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    function automatic logic maj3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_filt_q <= maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
            sda_filt_q <= maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl = scl_filt_q;
    assign sda = sda_filt_q;
`else
    assign scl = scl_s;
    assign sda = sda_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl;
            sda_prev_q <= sda;
        end
    end

    assign scl_rise  = scl & ~scl_prev_q;
    assign scl_fall  = ~scl & scl_prev_q;
    assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_als_responder.sv
// I2C target emulating the ALS sensor: CTRL register plus a coherent CCT shadow (MSB/LSB).
// Optional input glitch filter: define I2C_ALS_GLITCH_FILTER_EN.
module i2c_als_responder
    import i2c_als_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter logic [7:0]  CCT_MSB_REG = 8'h04,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    i2c_als_if.slave    bus,
    input  logic [15:0] cct_in,
    input  logic        cct_load,
    output logic [7:0]  ctrl_out,
    output logic        busy
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (bus.scl_in),
        .sda_in   (bus.sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    als_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q;
    logic [15:0] shadow_q, pend_q;
    logic        pend_v_q;
    logic [7:0]  rd_data;

    always_comb begin
        rd_data = 8'h00;
        if (ptr_q == CTRL_REG) begin
            rd_data = ctrl_q;
        end else if (ptr_q == CCT_MSB_REG) begin
            rd_data = shadow_q[15:8];
        end else if (ptr_q == CCT_MSB_REG + 8'd1) begin
            rd_data = shadow_q[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        ctrl_d   = ctrl_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d  = StAddr;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shift_q[6:0] == DEV_ADDR) begin
                                rw_d    = sda;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                // First fall after the byte pulls SDA low, the next one ends the ACK.
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            state_d  = StRdData;
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[7];
                            cnt_d    = 4'd0;
                        end else begin
                            state_d  = StPtr;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                        end
                    end
                end
                StPtr: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d   = {shift_q[6:0], sda};
                            cnt_d   = 4'd0;
                            state_d = StPtrAck;
                        end
                    end
                end
                StPtrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (ptr_q == CTRL_REG) begin
                                ctrl_d = {shift_q[6:0], sda};
                            end
                            ptr_d   = ptr_q + 8'd1;
                            cnt_d   = 4'd0;
                            state_d = StWrAck;
                        end
                    end
                end
                // cnt counts SCL rises; the fall after the 8th rise hands SDA to the master.
                StRdData: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdAck;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = StIdle;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        state_d  = StRdData;
                        shift_d  = rd_data;
                        sda_oe_d = ~rd_data[7];
                        cnt_d    = 4'd0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            shift_q  <= 8'h00;
            ptr_q    <= 8'h00;
            ctrl_q   <= 8'h00;
            rw_q     <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= 16'h0000;
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            ctrl_q   <= ctrl_d;
            rw_q     <= rw_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= start_det | (busy_q & ~stop_det);
            // Loads during a transfer park in pend_q and land on the first idle clk.
            if (busy_q) begin
                if (cct_load) begin
                    pend_q   <= cct_in;
                    pend_v_q <= 1'b1;
                end
            end else begin
                pend_v_q <= 1'b0;
                if (cct_load) begin
                    shadow_q <= cct_in;
                end else if (pend_v_q) begin
                    shadow_q <= pend_q;
                end
            end
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign ctrl_out   = ctrl_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_als_responder.sv
// Directed bench: bit-banged I2C master, table of write/read-back vectors, corner sequences.
module tb_i2c_als_responder;

    localparam int Q = 8;
    localparam logic [6:0] DEV = 7'h39;

    logic        clk, rst_n;
    logic [15:0] cct_in;
    logic        cct_load;
    logic [7:0]  ctrl_out;
    logic        busy;
    logic        m_scl_low, m_sda_low;
    logic        sda_line;
    int          checks, failures;
    int          oe_cnt;

    i2c_als_if bus_if ();

    assign bus_if.scl_in = ~m_scl_low;
    assign sda_line      = ~(m_sda_low | bus_if.sda_oe);
    assign bus_if.sda_in = sda_line;

    i2c_als_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .cct_in  (cct_in),
        .cct_load(cct_load),
        .ctrl_out(ctrl_out),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst_n) oe_cnt <= 0;
        else if (bus_if.sda_oe) oe_cnt <= oe_cnt + 1;
    end

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic [7:0] exp_ctrl;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clock_bit(input logic out_bit, output logic in_bit);
        m_sda_low = ~out_bit;
        tick(Q);
        m_scl_low = 1'b0;
        tick(Q);
        in_bit = sda_line;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        tick(Q);
        m_scl_low = 1'b0;
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(Q);
        m_scl_low = 1'b0;
        tick(Q);
        m_sda_low = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(~master_ack, s);
    endtask

    task automatic addr_ptr(input logic [7:0] ptr, output logic [1:0] acks);
        logic a0, a1;
        i2c_start();
        write_byte({DEV, 1'b0}, a0);
        write_byte(ptr, a1);
        acks = {a0, a1};
    endtask

    task automatic restart_read(output logic ack);
        i2c_start();
        write_byte({DEV, 1'b1}, ack);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        cct_in   = v;
        cct_load = 1'b1;
        tick(1);
        cct_load = 1'b0;
    endtask

    initial begin
        logic [1:0] acks;
        logic       a;
        logic [7:0] b;
        int         oe0;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cct_in    = 16'h0000;
        cct_load  = 1'b0;
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;

        vecs[0] = '{8'h00, 8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'h04, 8'h77, 8'h1B, 8'h3C};
        vecs[3] = '{8'h05, 8'h11, 8'h58, 8'h3C};
        vecs[4] = '{8'h06, 8'h22, 8'h00, 8'h3C};
        vecs[5] = '{8'h80, 8'hFF, 8'h00, 8'h3C};

        tick(4);
        check("reset_sda_oe", bus_if.sda_oe, 1'b0);
        check("reset_ctrl", ctrl_out, 8'h00);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Idle load, then pointer write + repeated-START read of both CCT bytes.
        pulse_load(16'h1B58);
        tick(2);
        addr_ptr(8'h04, acks);
        restart_read(a);
        check("cct_rd_acks", {acks, a}, 3'b111);
        read_byte(1'b1, b);
        check("cct_msb", b, 8'h1B);
        read_byte(1'b0, b);
        check("cct_lsb", b, 8'h58);
        i2c_stop();

        for (int i = 0; i < 6; i++) begin
            addr_ptr(vecs[i].ptr, acks);
            write_byte(vecs[i].wdata, a);
            check($sformatf("v%0d_wr_acks", i), {acks, a}, 3'b111);
            check($sformatf("v%0d_busy_hi", i), busy, 1'b1);
            i2c_stop();
            check($sformatf("v%0d_busy_lo", i), busy, 1'b0);
            check($sformatf("v%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
            addr_ptr(vecs[i].ptr, acks);
            restart_read(a);
            check($sformatf("v%0d_rd_acks", i), {acks, a}, 3'b111);
            read_byte(1'b0, b);
            check($sformatf("v%0d_rd", i), b, vecs[i].exp_rd);
            i2c_stop();
        end

        // Wrong address: no ACK, SDA never pulled, CTRL untouched.
        oe0 = oe_cnt;
        i2c_start();
        write_byte(8'h74, a);
        check("nomatch_addr_ack", a, 1'b0);
        write_byte(8'h00, a);
        check("nomatch_ptr_ack", a, 1'b0);
        write_byte(8'h99, a);
        check("nomatch_data_ack", a, 1'b0);
        i2c_stop();
        check("nomatch_oe_cnt", oe_cnt - oe0, 0);
        check("nomatch_ctrl", ctrl_out, 8'h3C);

        // Loads during a read stay pending (last one wins) until after STOP.
        addr_ptr(8'h04, acks);
        restart_read(a);
        read_byte(1'b1, b);
        check("coh_msb_old", b, 8'h1B);
        pulse_load(16'h1234);
        tick(2);
        pulse_load(16'h0FA0);
        read_byte(1'b0, b);
        check("coh_lsb_old", b, 8'h58);
        i2c_stop();
        addr_ptr(8'h04, acks);
        restart_read(a);
        read_byte(1'b1, b);
        check("coh_msb_new", b, 8'h0F);
        read_byte(1'b0, b);
        check("coh_lsb_new", b, 8'hA0);
        i2c_stop();

        // Pointer wraps 0xFF -> 0x00 during a burst read.
        addr_ptr(8'hFF, acks);
        restart_read(a);
        check("wrap_acks", {acks, a}, 3'b111);
        read_byte(1'b1, b);
        check("wrap_b0", b, 8'h00);
        read_byte(1'b1, b);
        check("wrap_b1", b, 8'h3C);
        read_byte(1'b1, b);
        check("wrap_b2", b, 8'h00);
        read_byte(1'b0, b);
        check("wrap_b3", b, 8'h00);
        i2c_stop();

        // Reset while driving bit 7 (=0) of CTRL.
        addr_ptr(8'h00, acks);
        restart_read(a);
        check("rst_pre_oe", bus_if.sda_oe, 1'b1);
        check("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("rst_sda_oe", bus_if.sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", ctrl_out, 8'h00);
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(Q);
        addr_ptr(8'h04, acks);
        restart_read(a);
        read_byte(1'b0, b);
        check("rst_shadow", b, 8'h00);
        i2c_stop();
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
